video_text_console_writer: RTL and testbench
============================================

# video_text_console_writer

Character-stream writer for the video text console character RAM. Accepts one byte per handshake (from the CPU/UART/debug path) and turns printable codes and a small set of control codes into writes to the console RAM write port. It tracks a cursor, wraps lines and screens, and clears rows and the screen with sequential fill sequences. It is the write-side counterpart of the console display, which reads the same RAM and renders it.

## Interface
- TW, 80: console width in characters
- TH, 2: console height in characters
- MAW, 8: console RAM address width; TW*TH <= 2**MAW is required
- MDW, 8: console RAM data width; must be >= 8
- clk  in  1  clock; also drives the console RAM write clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  clock enable; all state advances only when 1
- clr  in  1  clear-screen request, sampled in IDLE
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid && in_ready && clk_en
- in_dat  in  8  input byte
- busy  out  1  fill sequence in progress (state != IDLE)
- con_we  out  1  console RAM write enable (registered)
- con_adr_w  out  MAW  console RAM write address (registered)
- con_dat_w  out  MDW  console RAM write data (registered, zero-extended byte)
- cur_x  out  $clog2(TW)  cursor column
- cur_y  out  $clog2(TH)  cursor row

The integrator ties con_clk_w to clk and con_clk_en_w to clk_en.

## Operation
- States: IDLE, CLR_ALL, CLR_LINE. The reset state is CLR_ALL, so the RAM is blanked after every reset.
- Reset values: con_we=0, con_adr_w=0, con_dat_w=0x20, cur_x=0, cur_y=0, busy=1, in_ready=0.
- in_ready = (state==IDLE) && !clr, combinational.
- A line-base register holds cur_y*TW and is updated by adding or subtracting TW; no multiplier is used.
- Write address = base + cur_x, truncated to MAW bits.
- IDLE with clr=1: enter CLR_ALL. clr has priority over in_valid, and no byte is accepted that cycle. clr is ignored outside IDLE.
- Accepted byte, printable 0x20..0x7E:
  - Write the byte at the cursor.
  - If cur_x < TW-1: cur_x+1.
  - Else: cur_x=0, cur_y=(cur_y+1) mod TH, then enter CLR_LINE for the new row.
- 0x0A LF: cur_x=0, cur_y=(cur_y+1) mod TH, enter CLR_LINE. No character write.
- 0x0D CR: cur_x=0.
- 0x08 BS: cur_x=cur_x-1, saturating at 0. Nothing is erased.
- 0x0C FF: enter CLR_ALL.
- All other codes (0x00..0x1F not listed above, 0x7F, 0x80..0xFF): accepted and discarded; no state change.
- CLR_ALL: writes 0x20 to addresses 0..TW*TH-1, one per clk_en cycle, ascending. Afterwards cur_x=0, cur_y=0, base=0, and the state returns to IDLE.
- CLR_LINE: writes 0x20 to addresses base..base+TW-1, ascending, then returns to IDLE. The cursor stays at (0, new row).
- There is no scrolling. A wrap from the last row goes to row 0, and row 0 is cleared.

## Timing
- Every operation, including each fill write, is one clk_en cycle. When clk_en=0, all registers hold, including con_we.
- Write latency: a byte accepted on clk_en cycle n appears as con_we=1 with its address and data on cycle n+1.
- con_we is high for exactly one clk_en cycle per write. It is 0 on cycles where a control code or ignored code is accepted.
- Fill sequences:
  - CLR_ALL takes TW*TH clk_en cycles.
  - CLR_LINE takes TW clk_en cycles.
  - con_we is high on each of those cycles.
  - busy falls on the same edge that issues the last fill write's registered outputs, so in_ready can be 1 on the following cycle.
- Wrap from a printable byte: the character write at (TW-1, row) is followed immediately by the TW line-clear writes, with no gap.
- Reset asserted mid-sequence immediately forces the reset values. After release, a full CLR_ALL restarts from address 0.

## Test plan
- Reset release, TW=80, TH=2, clk_en=1: 160 consecutive con_we pulses with addresses 0..159 and data 0x20. After that busy=0, in_ready=1, cursor (0,0).
- Send "A" (0x41): next cycle con_we=1, con_adr_w=0, con_dat_w=0x41; cur_x=1.
- Send 80 x 0x42 on row 0: writes to addresses 0..79, then 80 clear writes to 80..159. Cursor ends at (0,1) and busy is high for exactly 80 cycles.
- From row 1, send LF: no character write; clear writes to 0..79; cursor (0,0). Then send 0x00 and 0x7F: accepted, no con_we, cursor unchanged.
- At cursor (3,0): send BS x4 then CR. cur_x goes 2,1,0,0 then 0, with no writes. Then send FF: 160 clear writes and cursor (0,0).
- Toggle clk_en 1-of-3 during CLR_LINE: the write sequence and count are unchanged, with one write per enabled cycle. Assert rst mid-fill: outputs return to reset values and CLR_ALL restarts at address 0. Assert clr and in_valid together in IDLE: the byte is not accepted and CLR_ALL starts.

Source files
------------

// File: rtl/video_text_console_writer.sv
// video_text_console_writer
// Turns a byte stream into writes on the console character RAM write port.
// Printable bytes go to the cursor cell; LF/CR/BS/FF move the cursor or start
// fills. Row and screen clears are one space write per clk_en cycle.
//
// Ports
//   clk, rst            clock and async active-high reset
//   clk_en_i            every register advances only when this is 1
//   clr_i               clear-screen request, only acted on in IDLE
//   in_valid_i/in_ready_o/in_dat_i   byte handshake
//   busy_o              a fill sequence is running
//   con_we_o, con_adr_w_o, con_dat_w_o   registered RAM write port
//   cur_x_o, cur_y_o    cursor column / row
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | accepting bytes and clear requests
// S_CLR_ALL  | writing spaces to every cell, then cursor home
// S_CLR_LINE | writing spaces across the row at base_q
module video_text_console_writer #(
    parameter int TW  = 80,
    parameter int TH  = 2,
    parameter int MAW = 8,
    parameter int MDW = 8,
    localparam int XW = (TW > 1) ? $clog2(TW) : 1,
    localparam int YW = (TH > 1) ? $clog2(TH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clk_en_i,
    input  logic           clr_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [7:0]     in_dat_i,
    output logic           busy_o,
    output logic           con_we_o,
    output logic [MAW-1:0] con_adr_w_o,
    output logic [MDW-1:0] con_dat_w_o,
    output logic [XW-1:0]  cur_x_o,
    output logic [YW-1:0]  cur_y_o
);

    localparam int CW = (TW * TH > 1) ? $clog2(TW * TH) : 1;
    localparam logic [CW-1:0]  ALL_LAST  = CW'(TW * TH - 1);
    localparam logic [CW-1:0]  LINE_LAST = CW'(TW - 1);
    localparam logic [MAW-1:0] TW_A      = MAW'(TW);
    localparam logic [MDW-1:0] SPACE     = MDW'(8'h20);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR_ALL,
        S_CLR_LINE
    } state_t;

    state_t         state_q, state_d;
    logic [MAW-1:0] base_q, base_d;
    logic [MAW-1:0] fadr_q, fadr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [XW-1:0]  cur_x_q, cur_x_d;
    logic [YW-1:0]  cur_y_q, cur_y_d;
    logic           con_we_q, con_we_d;
    logic [MAW-1:0] con_adr_q, con_adr_d;
    logic [MDW-1:0] con_dat_q, con_dat_d;

    logic [MAW-1:0] cur_adr;
    logic           last_col;
    logic           last_row;
    logic [MAW-1:0] nl_base;
    logic [YW-1:0]  nl_y;
    logic           do_nl;
    logic           do_all;

    assign in_ready_o  = (state_q == S_IDLE) && !clr_i;
    assign busy_o      = (state_q != S_IDLE);
    assign con_we_o    = con_we_q;
    assign con_adr_w_o = con_adr_q;
    assign con_dat_w_o = con_dat_q;
    assign cur_x_o     = cur_x_q;
    assign cur_y_o     = cur_y_q;

    // base_q always equals cur_y_q*TW; it is stepped by TW instead of multiplied.
    assign cur_adr  = base_q + MAW'(cur_x_q);
    assign last_col = (cur_x_q == XW'(TW - 1));
    assign last_row = (cur_y_q == YW'(TH - 1));
    assign nl_base  = last_row ? '0 : base_q + TW_A;
    assign nl_y     = last_row ? '0 : cur_y_q + YW'(1);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        fadr_d    = fadr_q;
        cnt_d     = cnt_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        con_we_d  = 1'b0;
        con_adr_d = con_adr_q;
        con_dat_d = con_dat_q;
        do_nl     = 1'b0;
        do_all    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (clr_i) begin
                    do_all = 1'b1;
                end else if (in_valid_i) begin
                    if (in_dat_i >= 8'h20 && in_dat_i <= 8'h7E) begin
                        con_we_d  = 1'b1;
                        con_adr_d = cur_adr;
                        con_dat_d = MDW'(in_dat_i);
                        if (last_col) do_nl = 1'b1;
                        else          cur_x_d = cur_x_q + XW'(1);
                    end else begin
                        case (in_dat_i)
                            8'h0A: do_nl = 1'b1;
                            8'h0D: cur_x_d = '0;
                            8'h08: if (cur_x_q != '0) cur_x_d = cur_x_q - XW'(1);
                            8'h0C: do_all = 1'b1;
                            default: ;
                        endcase
                    end
                end
                if (do_nl) begin
                    cur_x_d = '0;
                    cur_y_d = nl_y;
                    base_d  = nl_base;
                    fadr_d  = nl_base;
                    cnt_d   = LINE_LAST;
                    state_d = S_CLR_LINE;
                end
                if (do_all) begin
                    fadr_d  = '0;
                    cnt_d   = ALL_LAST;
                    state_d = S_CLR_ALL;
                end
            end
            S_CLR_ALL, S_CLR_LINE: begin
                con_we_d  = 1'b1;
                con_adr_d = fadr_q;
                con_dat_d = SPACE;
                fadr_d    = fadr_q + MAW'(1);
                cnt_d     = cnt_q - CW'(1);
                // Leaving on the last write's edge lets in_ready rise the next cycle.
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (state_q == S_CLR_ALL) begin
                        cur_x_d = '0;
                        cur_y_d = '0;
                        base_d  = '0;
                    end
                end
            end
            default: state_d = S_CLR_ALL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_CLR_ALL;
            base_q    <= '0;
            fadr_q    <= '0;
            cnt_q     <= ALL_LAST;
            cur_x_q   <= '0;
            cur_y_q   <= '0;
            con_we_q  <= 1'b0;
            con_adr_q <= '0;
            con_dat_q <= SPACE;
        end else if (clk_en_i) begin
            state_q   <= state_d;
            base_q    <= base_d;
            fadr_q    <= fadr_d;
            cnt_q     <= cnt_d;
            cur_x_q   <= cur_x_d;
            cur_y_q   <= cur_y_d;
            con_we_q  <= con_we_d;
            con_adr_q <= con_adr_d;
            con_dat_q <= con_dat_d;
        end
    end

endmodule

// File: tb/tb_video_text_console_writer.sv
module tb_video_text_console_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_dat = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       con_we;
    logic [7:0] con_adr;
    logic [7:0] con_dat;
    logic [6:0] cur_x;
    logic [0:0] cur_y;

    int total = 0;
    int bad = 0;

    video_text_console_writer #(.TW(80), .TH(2), .MAW(8), .MDW(8)) dut (
        .clk(clk), .rst(rst), .clk_en_i(clk_en), .clr_i(clr),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_dat_i(in_dat),
        .busy_o(busy), .con_we_o(con_we), .con_adr_w_o(con_adr),
        .con_dat_w_o(con_dat), .cur_x_o(cur_x), .cur_y_o(cur_y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_dat = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({con_we, con_adr, con_dat, busy, in_ready, cur_x, cur_y} !== {1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_vals actual=%h required=%h", {con_we, con_adr, con_dat, busy, in_ready, cur_x, cur_y},
                     {1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 7'd0, 1'b0});
        end
        rst = 1'b0;
        for (int i = 0; i < 160; i++) begin
            tick();
            total++;
            if ({con_we, busy, con_adr, con_dat} !== {1'b1, (i < 159), 8'(i), 8'h20}) begin
                bad++;
                $display("FAIL reset_fill[%0d] actual=%h required=%h", i, {con_we, busy, con_adr, con_dat}, {1'b1, (i < 159), 8'(i), 8'h20});
            end
        end
        total++;
        if ({busy, in_ready, cur_x, cur_y} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_done actual=%h required=%h", {busy, in_ready, cur_x, cur_y}, {1'b0, 1'b1, 7'd0, 1'b0});
        end
    endtask

    task automatic test_write_a();
        send(8'h41);
        total++;
        if ({con_we, con_adr, con_dat, cur_x} !== {1'b1, 8'd0, 8'h41, 7'd1}) begin
            bad++;
            $display("FAIL write_a actual=%h required=%h", {con_we, con_adr, con_dat, cur_x}, {1'b1, 8'd0, 8'h41, 7'd1});
        end
        send(8'h0D);
        total++;
        if ({con_we, cur_x, cur_y} !== {1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL cr_after_a actual=%h required=%h", {con_we, cur_x, cur_y}, {1'b0, 7'd0, 1'b0});
        end
    endtask

    task automatic test_wrap();
        int busy_cnt;
        for (int i = 0; i < 80; i++) begin
            send(8'h42);
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(i), 8'h42}) begin
                bad++;
                $display("FAIL wrap_char[%0d] actual=%h required=%h", i, {con_we, con_adr, con_dat}, {1'b1, 8'(i), 8'h42});
            end
        end
        total++;
        if ({busy, cur_x, cur_y} !== {1'b1, 7'd0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_cursor actual=%h required=%h", {busy, cur_x, cur_y}, {1'b1, 7'd0, 1'b1});
        end
        busy_cnt = busy ? 1 : 0;
        for (int j = 0; j < 80; j++) begin
            tick();
            if (busy) busy_cnt++;
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(80 + j), 8'h20}) begin
                bad++;
                $display("FAIL wrap_clear[%0d] actual=%h required=%h", j, {con_we, con_adr, con_dat}, {1'b1, 8'(80 + j), 8'h20});
            end
        end
        total++;
        if (busy_cnt != 80) begin
            bad++;
            $display("FAIL wrap_busy_cycles actual=%0d required=80", busy_cnt);
        end
        total++;
        if ({in_ready, cur_x, cur_y} !== {1'b1, 7'd0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_done actual=%h required=%h", {in_ready, cur_x, cur_y}, {1'b1, 7'd0, 1'b1});
        end
    endtask

    task automatic test_lf();
        send(8'h0A);
        total++;
        if ({con_we, busy, cur_x, cur_y} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL lf_accept actual=%h required=%h", {con_we, busy, cur_x, cur_y}, {1'b0, 1'b1, 7'd0, 1'b0});
        end
        for (int j = 0; j < 80; j++) begin
            tick();
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(j), 8'h20}) begin
                bad++;
                $display("FAIL lf_clear[%0d] actual=%h required=%h", j, {con_we, con_adr, con_dat}, {1'b1, 8'(j), 8'h20});
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL lf_busy actual=%b required=0", busy);
        end
        send(8'h00);
        total++;
        if ({con_we, busy, cur_x, cur_y} !== {1'b0, 1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL ignore_00 actual=%h required=%h", {con_we, busy, cur_x, cur_y}, {1'b0, 1'b0, 7'd0, 1'b0});
        end
        send(8'h7F);
        total++;
        if ({con_we, busy, in_ready, cur_x, cur_y} !== {1'b0, 1'b0, 1'b1, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL ignore_7f actual=%h required=%h", {con_we, busy, in_ready, cur_x, cur_y}, {1'b0, 1'b0, 1'b1, 7'd0, 1'b0});
        end
    endtask

    task automatic test_bs_cr_ff();
        int bs_exp[4] = '{2, 1, 0, 0};
        send(8'h31);
        send(8'h32);
        send(8'h33);
        total++;
        if ({con_we, con_adr, con_dat, cur_x} !== {1'b1, 8'd2, 8'h33, 7'd3}) begin
            bad++;
            $display("FAIL bs_setup actual=%h required=%h", {con_we, con_adr, con_dat, cur_x}, {1'b1, 8'd2, 8'h33, 7'd3});
        end
        for (int k = 0; k < 4; k++) begin
            send(8'h08);
            total++;
            if ({con_we, cur_x, cur_y} !== {1'b0, 7'(bs_exp[k]), 1'b0}) begin
                bad++;
                $display("FAIL bs[%0d] actual=%h required=%h", k, {con_we, cur_x, cur_y}, {1'b0, 7'(bs_exp[k]), 1'b0});
            end
        end
        send(8'h0D);
        total++;
        if ({con_we, cur_x} !== {1'b0, 7'd0}) begin
            bad++;
            $display("FAIL cr actual=%h required=%h", {con_we, cur_x}, {1'b0, 7'd0});
        end
        send(8'h0C);
        total++;
        if ({con_we, busy} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL ff_accept actual=%h required=%h", {con_we, busy}, {1'b0, 1'b1});
        end
        for (int i = 0; i < 160; i++) begin
            tick();
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(i), 8'h20}) begin
                bad++;
                $display("FAIL ff_fill[%0d] actual=%h required=%h", i, {con_we, con_adr, con_dat}, {1'b1, 8'(i), 8'h20});
            end
        end
        total++;
        if ({busy, cur_x, cur_y} !== {1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL ff_done actual=%h required=%h", {busy, cur_x, cur_y}, {1'b0, 7'd0, 1'b0});
        end
    endtask

    task automatic test_clk_en();
        int k = 0;
        send(8'h0A);
        for (int c = 0; c < 300 && k < 80; c++) begin
            clk_en = (c % 3 == 0);
            tick();
            if (clk_en) begin
                total++;
                if ({con_we, con_adr, con_dat} !== {1'b1, 8'(80 + k), 8'h20}) begin
                    bad++;
                    $display("FAIL ce_write[%0d] actual=%h required=%h", k, {con_we, con_adr, con_dat}, {1'b1, 8'(80 + k), 8'h20});
                end
                k++;
            end else begin
                total++;
                if ({con_we, con_adr, busy} !== {1'b1, 8'(79 + k), 1'b1}) begin
                    bad++;
                    $display("FAIL ce_hold[%0d] actual=%h required=%h", c, {con_we, con_adr, busy}, {1'b1, 8'(79 + k), 1'b1});
                end
            end
        end
        clk_en = 1'b1;
        total++;
        if (k != 80) begin
            bad++;
            $display("FAIL ce_count actual=%0d required=80", k);
        end
        total++;
        if ({busy, cur_x, cur_y} !== {1'b0, 7'd0, 1'b1}) begin
            bad++;
            $display("FAIL ce_done actual=%h required=%h", {busy, cur_x, cur_y}, {1'b0, 7'd0, 1'b1});
        end
    endtask

    task automatic test_rst_mid();
        send(8'h0C);
        repeat (20) tick();
        total++;
        if ({con_we, con_adr, cur_y} !== {1'b1, 8'd19, 1'b1}) begin
            bad++;
            $display("FAIL rst_pre actual=%h required=%h", {con_we, con_adr, cur_y}, {1'b1, 8'd19, 1'b1});
        end
        rst = 1'b1;
        #1;
        total++;
        if ({con_we, con_adr, con_dat, busy, in_ready, cur_x, cur_y} !== {1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL rst_mid_vals actual=%h required=%h", {con_we, con_adr, con_dat, busy, in_ready, cur_x, cur_y},
                     {1'b0, 8'h00, 8'h20, 1'b1, 1'b0, 7'd0, 1'b0});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 160; i++) begin
            tick();
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(i), 8'h20}) begin
                bad++;
                $display("FAIL rst_refill[%0d] actual=%h required=%h", i, {con_we, con_adr, con_dat}, {1'b1, 8'(i), 8'h20});
            end
        end
        total++;
        if ({busy, in_ready} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_refill_done actual=%h required=%h", {busy, in_ready}, {1'b0, 1'b1});
        end
    endtask

    task automatic test_clr_priority();
        send(8'h41);
        clr = 1'b1;
        in_valid = 1'b1;
        in_dat = 8'h43;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL clr_ready actual=%b required=0", in_ready);
        end
        tick();
        in_valid = 1'b0;
        total++;
        if ({con_we, busy, cur_x} !== {1'b0, 1'b1, 7'd1}) begin
            bad++;
            $display("FAIL clr_accept actual=%h required=%h", {con_we, busy, cur_x}, {1'b0, 1'b1, 7'd1});
        end
        for (int i = 0; i < 160; i++) begin
            clr = (i >= 50 && i < 60);
            tick();
            total++;
            if ({con_we, con_adr, con_dat} !== {1'b1, 8'(i), 8'h20}) begin
                bad++;
                $display("FAIL clr_fill[%0d] actual=%h required=%h", i, {con_we, con_adr, con_dat}, {1'b1, 8'(i), 8'h20});
            end
        end
        total++;
        if ({busy, in_ready, cur_x, cur_y} !== {1'b0, 1'b1, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL clr_done actual=%h required=%h", {busy, in_ready, cur_x, cur_y}, {1'b0, 1'b1, 7'd0, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_wrap();
        test_lf();
        test_bs_cr_ff();
        test_clk_en();
        test_rst_mid();
        test_clr_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
